// File: rtl/fir_pkg.sv
// Shared types and helpers for the parametrised transposed-form FIR.
package fir_pkg;

    // Coefficient loader states.
    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_LOAD   = 2'd1,
        LD_COMMIT = 2'd2
    } ld_state_e;

    // Result of the round/saturate stage: 64-bit value plus clip flag.
    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_res_t;

    // Ceiling log2, used only to size parameters (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Round half up after an arithmetic right shift, then clip to a signed
    // ow-bit range. The accumulator is passed sign-extended to 64 bits, so
    // adding the rounding constant can never overflow.
    function automatic sat_res_t sat_round(input logic signed [63:0] y,
                                           input int                 ow,
                                           input int                 shift);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           res;
        if (shift > 0) r = (y + (64'sd1 <<< (shift - 1))) >>> shift;
        else           r = y;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        res.sat = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Coefficient loader: collects NTAPS words into a shadow bank, then raises
// a one-cycle commit pulse so the filter swaps banks atomically.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int CW    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coef_wr_en,
    input  logic signed [CW-1:0]          coef_wr_data,
    output logic                          coef_busy,
    output logic                          commit,
    output logic [NTAPS-1:0][CW-1:0]      shadow,
    output ld_state_e                     state_o
);

    localparam int CNTW = clog2(NTAPS);

    ld_state_e                 state_q, state_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic [NTAPS-1:0][CW-1:0]  shadow_q, shadow_d;

    // Next-state, counter and shadow-bank write logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        case (state_q)
            LD_IDLE: begin
                if (coef_wr_en) begin
                    shadow_d[0] = coef_wr_data;
                    cnt_d       = CNTW'(1);
                    state_d     = LD_LOAD;
                end
            end
            LD_LOAD: begin
                if (coef_wr_en) begin
                    shadow_d[cnt_q] = coef_wr_data;
                    cnt_d           = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(NTAPS - 1)) state_d = LD_COMMIT;
                end
            end
            LD_COMMIT: begin
                // Writes arriving here are dropped; the bank is being swapped.
                cnt_d   = '0;
                state_d = LD_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = LD_IDLE;
            end
        endcase
    end

    // State, counter and shadow registers; reset discards any partial load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LD_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign coef_busy = (state_q != LD_IDLE);
    assign commit    = (state_q == LD_COMMIT);
    assign shadow    = shadow_q;
    assign state_o   = state_q;

endmodule

// File: rtl/tpf_fir_param.sv
// N-tap transposed-form FIR with valid-qualified advance, atomic coefficient
// reload and a rounded, saturated registered output.
module tpf_fir_param
    import fir_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 19,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic                 coef_wr_en,
    input  logic signed [CW-1:0] coef_wr_data,
    output logic                 coef_busy,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat
);

    localparam int AW = DW + CW + clog2(NTAPS);
    // Passthrough bank: h0 = 1, all other taps 0.
    localparam logic [NTAPS*CW-1:0] ACT_RST = (NTAPS*CW)'(1);

    logic                         commit;
    logic [NTAPS-1:0][CW-1:0]     shadow;
    ld_state_e                    ld_state;

    // act_q holds the live bank; z_q[i] is partial sum z(i+1).
    logic [NTAPS-1:0][CW-1:0]     act_q, act_d;
    logic [NTAPS-2:0][AW-1:0]     z_q, z_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [OW-1:0]         out_data_q, out_data_d;
    logic                         out_sat_q, out_sat_d;

    logic signed [AW-1:0]         p [NTAPS];
    logic signed [AW-1:0]         y;
    sat_res_t                     rs;
    logic                         unused_bits;

    fir_coef_loader #(
        .NTAPS (NTAPS),
        .CW    (CW)
    ) u_loader (
        .clk          (clk),
        .rst          (rst),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_data (coef_wr_data),
        .coef_busy    (coef_busy),
        .commit       (commit),
        .shadow       (shadow),
        .state_o      (ld_state)
    );

    // Tap products, full-precision sum and round/saturate of the current sample.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            p[k] = AW'($signed(act_q[k])) * AW'(in_data);
        end
        y  = p[0] + $signed(z_q[0]);
        rs = sat_round(64'(y), OW, SHIFT);
    end

    // Chain and output next-state: advance on in_valid, clear on commit.
    always_comb begin
        act_d       = act_q;
        z_d         = z_q;
        out_valid_d = in_valid;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (in_valid) begin
            for (int i = 0; i < NTAPS - 2; i++) begin
                z_d[i] = p[i+1] + $signed(z_q[i+1]);
            end
            z_d[NTAPS-2] = p[NTAPS-1];
            out_data_d   = rs.val[OW-1:0];
            out_sat_d    = rs.sat;
        end
        // The commit clear overrides the chain update of a same-cycle sample;
        // that sample's output is still produced from the old bank.
        if (commit) begin
            act_d = shadow;
            z_d   = '0;
        end
    end

    // Filter state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q       <= ACT_RST;
            z_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            act_q       <= act_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Loader state is exported for observation only; upper result bits are
    // already reflected in the saturation decision.
    assign unused_bits = ^{ld_state, rs.val[63:OW]};

endmodule

// File: tb/tb_tpf_fir_param.sv
// Bench for tpf_fir_param: SHIFT=0 and SHIFT=1 instances share stimulus and
// are scored against a convolution model over the sample history.
module tb_tpf_fir_param;

    localparam int NTAPS = 4;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int OW    = 19;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 coef_wr_en;
    logic signed [CW-1:0] coef_wr_data;
    logic                 coef_busy0, coef_busy1;
    logic                 out_valid0, out_valid1;
    logic signed [OW-1:0] out_data0, out_data1;
    logic                 out_sat0, out_sat1;

    tpf_fir_param #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .coef_wr_en(coef_wr_en), .coef_wr_data(coef_wr_data), .coef_busy(coef_busy0),
        .out_valid(out_valid0), .out_data(out_data0), .out_sat(out_sat0));

    tpf_fir_param #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .coef_wr_en(coef_wr_en), .coef_wr_data(coef_wr_data), .coef_busy(coef_busy1),
        .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1));

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // Expected words are {sat, data}.
    logic [OW:0] exp_q[$];
    logic [OW:0] exp1_q[$];
    longint      h_act[NTAPS];
    longint      hist[$];
    logic [OW:0] last0, last1;

    function automatic logic [OW:0] round_sat(input longint acc, input int sh);
        longint r, d, n, hi, lo;
        if (sh == 0) begin
            r = acc;
        end else begin
            d = longint'(1) << sh;
            n = acc + d / 2;
            if (n >= 0) r = n / d;
            else        r = -((-n + d - 1) / d);
        end
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        if (r > hi) return {1'b1, OW'(hi)};
        if (r < lo) return {1'b1, OW'(lo)};
        return {1'b0, OW'(r)};
    endfunction

    // y[n] = sum_k h[k] * x[n-k], samples before the last clear count as 0.
    task automatic model_push(input longint x);
        longint acc;
        hist.push_back(x);
        if (hist.size() > NTAPS) void'(hist.pop_front());
        acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (k < hist.size()) acc += h_act[k] * hist[hist.size() - 1 - k];
        end
        exp_q.push_back(round_sat(acc, 0));
        exp1_q.push_back(round_sat(acc, 1));
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [OW:0] e;
        if (rst) begin
            last0 = '0;
            last1 = '0;
        end else begin
            if (out_valid0) begin
                vectors++;
                assert (exp_q.size() > 0) else begin
                    miscompares++;
                    $error("FAIL y0_spurious: out_valid=1 with nothing expected, data=%0d", out_data0);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    vectors++;
                    assert ({out_sat0, out_data0} === e) else begin
                        miscompares++;
                        $error("FAIL y0: got sat=%0b data=%0d, want sat=%0b data=%0d",
                               out_sat0, out_data0, e[OW], $signed(e[OW-1:0]));
                    end
                    last0 = e;
                end
            end else begin
                vectors++;
                assert ({out_sat0, out_data0} === last0) else begin
                    miscompares++;
                    $error("FAIL y0_hold: got sat=%0b data=%0d, want sat=%0b data=%0d",
                           out_sat0, out_data0, last0[OW], $signed(last0[OW-1:0]));
                end
            end
            if (out_valid1) begin
                vectors++;
                assert (exp1_q.size() > 0) else begin
                    miscompares++;
                    $error("FAIL y1_spurious: out_valid=1 with nothing expected, data=%0d", out_data1);
                end
                if (exp1_q.size() > 0) begin
                    e = exp1_q.pop_front();
                    vectors++;
                    assert ({out_sat1, out_data1} === e) else begin
                        miscompares++;
                        $error("FAIL y1_shift: got sat=%0b data=%0d, want sat=%0b data=%0d",
                               out_sat1, out_data1, e[OW], $signed(e[OW-1:0]));
                    end
                    last1 = e;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input longint x);
        in_valid = v;
        in_data  = DW'(x);
        if (v) model_push(x);
    endtask

    function automatic longint rand_sample();
        case ($urandom_range(0, 5))
            0:       return 32767;
            1:       return -32768;
            default: return longint'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic traffic(input bit rnd);
        if (rnd) drive(1'($urandom_range(0, 1)), rand_sample());
        else     drive(1'b0, 0);
    endtask

    task automatic check_busy(input bit want, input string tag);
        vectors++;
        assert (coef_busy0 === want && coef_busy1 === want) else begin
            miscompares++;
            $error("FAIL %s: coef_busy got %0b/%0b, want %0b", tag, coef_busy0, coef_busy1, want);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        coef_wr_en   = 1'b0;
        coef_wr_data = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp1_q.delete();
        hist.delete();
        for (int k = 0; k < NTAPS; k++) h_act[k] = (k == 0) ? 1 : 0;
    endtask

    // Write a full bank; rnd adds write gaps, concurrent samples and a
    // write attempt during the commit cycle.
    task automatic load_coefs(input longint h[NTAPS], input bit rnd);
        check_busy(1'b0, "busy_before_load");
        coef_wr_en   = 1'b1;
        coef_wr_data = CW'(h[0]);
        traffic(rnd);
        for (int k = 1; k < NTAPS; k++) begin
            tick();
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    coef_wr_en = 1'b0;
                    traffic(rnd);
                    check_busy(1'b1, "busy_gap");
                    tick();
                end
            end
            check_busy(1'b1, "busy_load");
            coef_wr_en   = 1'b1;
            coef_wr_data = CW'(h[k]);
            traffic(rnd);
        end
        tick();
        check_busy(1'b1, "busy_commit");
        coef_wr_en   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        coef_wr_data = CW'($urandom_range(0, 65535));
        traffic(rnd);
        for (int k = 0; k < NTAPS; k++) h_act[k] = h[k];
        hist.delete();
        tick();
        coef_wr_en = 1'b0;
        drive(1'b0, 0);
        check_busy(1'b0, "busy_after_commit");
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        longint h[NTAPS];
        longint ramp[5];

        do_reset();
        vectors++;
        assert (out_valid0 === 1'b0 && out_data0 === '0 && out_sat0 === 1'b0) else begin
            miscompares++;
            $error("FAIL reset_out: valid=%0b data=%0d sat=%0b, want 0/0/0", out_valid0, out_data0, out_sat0);
        end
        check_busy(1'b0, "reset_busy");

        // Passthrough after reset (also exercises SHIFT=1 rounding).
        drive(1, 5);   tick();
        drive(1, -7);  tick();
        drive(1, 100); tick();
        drive(1, 3);   tick();
        drive(1, -3);  tick();
        drive(0, 0);   tick(); tick();

        // Impulse response of h = {1,2,3,4}.
        h = '{1, 2, 3, 4};
        load_coefs(h, 1'b0);
        for (int i = 0; i < 5; i++) begin drive(1, (i == 0) ? 1 : 0); tick(); end
        drive(0, 0); tick();

        // Ramp, then the same ramp with a 3-cycle valid gap.
        ramp = '{1, 2, 3, 4, 5};
        for (int i = 0; i < 5; i++) begin drive(1, ramp[i]); tick(); end
        for (int i = 0; i < NTAPS; i++) begin drive(1, 0); tick(); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                repeat (3) begin drive(0, 0); tick(); end
            end
            drive(1, ramp[i]);
            tick();
        end
        drive(0, 0); tick(); tick();

        // Saturation in both directions.
        h = '{32767, 32767, 32767, 32767};
        load_coefs(h, 1'b0);
        for (int i = 0; i < 4; i++) begin drive(1, 32767); tick(); end
        for (int i = 0; i < 4; i++) begin drive(1, -32768); tick(); end
        drive(0, 0); tick(); tick();

        // Reset part-way through a load restores passthrough.
        coef_wr_en = 1'b1; coef_wr_data = 16'sd9; tick();
        coef_wr_data = 16'sd8; tick();
        coef_wr_en = 1'b0;
        do_reset();
        check_busy(1'b0, "busy_after_midload_reset");
        for (int i = 0; i < 4; i++) begin drive(1, (i == 0) ? 1 : 0); tick(); end
        drive(0, 0); tick(); tick();

        // Randomised reloads with concurrent traffic.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (r == 3) h[k] = -32768;
                else        h[k] = longint'($urandom_range(0, 65535)) - 32768;
            end
            load_coefs(h, 1'b1);
            repeat (30) begin traffic(1'b1); tick(); end
            drive(0, 0); tick();
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && (exp_q.size() > 0 || exp1_q.size() > 0); i++) tick();
        vectors++;
        assert (exp_q.size() == 0 && exp1_q.size() == 0) else begin
            miscompares++;
            $error("FAIL drain: %0d/%0d outputs never arrived, want 0/0", exp_q.size(), exp1_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tpf_fir_param.md
Name: tpf_fir_param

Overview:
Parametrised transposed-form FIR filter, the N-tap successor to the fixed 4-tap transposed FIR.
- Signed two's-complement datapath with valid-qualified input and a stall-able pipeline.
- Runtime coefficient reload through a shadow bank, committed atomically.
- Rounded, saturated output.
- Sits in the DSP datapath between the sample source and downstream decimation/accumulation stages.

Parameters:
NTAPS, 4, number of taps (>=2)
DW, 16, input sample width (signed)
CW, 16, coefficient width (signed)
OW, 19, output width (signed)
SHIFT, 0, right shift applied to accumulator before rounding/saturation

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  sample strobe; pipeline advances only when high
in_data  in  DW  input sample x[n]
coef_wr_en  in  1  coefficient write strobe
coef_wr_data  in  CW  coefficient word, written in order h0..h(NTAPS-1)
coef_busy  out  1  high while a coefficient load is in progress
out_valid  out  1  output strobe
out_data  out  OW  filter output y[n]
out_sat  out  1  high with out_valid when out_data was clipped

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - out_valid=0, out_data=0, out_sat=0, coef_busy=0.
  - All partial-sum registers z1..z(NTAPS-1)=0.
  - Active coefficients = {1,0,...,0}, i.e. passthrough.
  - Shadow bank = 0; load counter = 0; FSM in IDLE.
- Full-precision width AW = DW+CW+clog2(NTAPS).
- Transposed form, updated only on cycles with in_valid=1:
  - p_k = h_k * in_data.
  - y = p_0 + z1.
  - z_k <= p_k + z_(k+1) for 1 <= k < NTAPS-1.
  - z_(NTAPS-1) <= p_(NTAPS-1).
- Latency: out_valid is in_valid delayed 1 cycle; out_data and out_sat are registered with it.
- When in_valid=0: z registers, out_data and out_sat hold; out_valid=0.
- Output post-processing:
  - r = (y + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift, round half up).
  - Saturate r to [-2^(OW-1), 2^(OW-1)-1]; out_sat=1 iff clipped.
- Coefficient loader FSM: IDLE, LOAD, COMMIT.
  - IDLE: coef_wr_en writes shadow[0], cnt<=1, go to LOAD; coef_busy=1 from the next cycle.
  - LOAD: each coef_wr_en writes shadow[cnt], cnt++. The write at cnt=NTAPS-1 goes to COMMIT. No timeout: gaps between writes are allowed.
  - COMMIT (one cycle): active bank <= shadow; all z registers cleared to 0; cnt<=0; go to IDLE; coef_busy drops the cycle after COMMIT.
- Simultaneous events:
  - in_valid during LOAD: filtering continues with the old active bank.
  - in_valid in the COMMIT cycle: the sample is filtered with the old bank, and its z updates are discarded by the clear (clear wins). Its y output is still produced.
  - coef_wr_en in the COMMIT cycle: ignored.
- Reset mid-load: shadow and cnt are discarded; active bank returns to passthrough.
- Output never wraps around; overflow always saturates.

Decomposition:
- Shared package fir_pkg:
  - Loader state enum (IDLE/LOAD/COMMIT).
  - clog2 function.
  - Saturate-and-round function parametrised by AW/OW/SHIFT.
- One natural sub-module, fir_coef_loader: FSM, counter, shadow bank, commit pulse. Top module holds the transposed tap chain and output stage.

Test Plan:
- Reset then in_valid with x=5,-7,100 -> out_data 5,-7,100 one cycle later (passthrough), out_sat=0.
- Load h={1,2,3,4}, then impulse x=1,0,0,0,0 -> out_data 1,2,3,4,0; coef_busy high exactly from the cycle after the first write until the cycle after COMMIT.
- h={1,2,3,4}, ramp x=1,2,3,4,5 -> 1,4,10,20,30. Repeat with in_valid low for 3 cycles mid-ramp -> same sequence, no out_valid during the gap.
- h all 32767, x=32767 for 4 samples -> out_data 262143, out_sat=1. x=-32768 with h all 32767 -> -262144, out_sat=1.
- SHIFT=1 build, h={1,0,0,0}, x=3,-3 -> 2,-1 (round half up).
- Assert rst after 2 of 4 coefficient writes -> coef_busy=0, impulse x=1 -> out 1,0,0,0 (passthrough restored).
